// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared drain FSM states and requantization helper for the MAC read-out path
package mac_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_t;

    // Working width for requant; holds any accumulator up to 31 bits plus one guard bit.
    localparam int REQ_W = 32;

    function automatic logic signed [REQ_W-1:0] requant(
        input logic signed [REQ_W-1:0] a,
        input int unsigned             sh,
        input int unsigned             cdw
    );
        logic signed [REQ_W-1:0] rnd;
        logic signed [REQ_W-1:0] t;
        logic signed [REQ_W-1:0] hi;
        logic signed [REQ_W-1:0] lo;
        if (sh == 0) begin
            t = a;
        end else begin
            rnd = 32'sd1 <<< (sh - 1);
            t   = (a + rnd) >>> sh;
        end
        hi = (32'sd1 <<< (cdw - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (cdw - 1));
        if (t > hi) begin
            return hi;
        end else if (t < lo) begin
            return lo;
        end
        return t;
    endfunction

endpackage

// File: rtl/mac_requant.sv
// rtl/mac_requant.sv - combinational arithmetic shift, round-half-up and saturate
module mac_requant
    import mac_pkg::*;
#(
    parameter int ADW = 16,
    parameter int CDW = 4,
    parameter int SW  = 4
) (
    input  logic [ADW-1:0] acc_i,
    input  logic [SW-1:0]  shift_i,
    output logic [CDW-1:0] data_o
);

    logic signed [REQ_W-1:0] a_ext;

    always_comb begin
        a_ext  = REQ_W'(signed'(acc_i));
        data_o = CDW'(requant(a_ext, 32'(shift_i), CDW));
    end

endmodule

// File: rtl/mac_drain.sv
// rtl/mac_drain.sv - snapshots the MAC accumulators, clears the array and streams requantized results
module mac_drain
    import mac_pkg::*;
#(
    parameter int ARRAY_SIZE             = 2,
    parameter int COMPUTE_DATA_WIDTH     = 4,
    parameter int ACCUMULATOR_DATA_WIDTH = 16,
    parameter int SHIFT_WIDTH            = $clog2(ACCUMULATOR_DATA_WIDTH),
    parameter int IDX_WIDTH              = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [SHIFT_WIDTH-1:0]            shift,
    input  logic [ACCUMULATOR_DATA_WIDTH-1:0] accumulator [ARRAY_SIZE],
    output logic                              acc_clear,
    output logic                              busy,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [COMPUTE_DATA_WIDTH-1:0]     out_data,
    output logic [IDX_WIDTH-1:0]              out_index,
    output logic                              out_last,
    output logic                              done
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(ARRAY_SIZE - 1);

    drain_state_t                        state_q, state_d;
    logic [ACCUMULATOR_DATA_WIDTH-1:0]   snap_q [ARRAY_SIZE];
    logic [ACCUMULATOR_DATA_WIDTH-1:0]   snap_d [ARRAY_SIZE];
    logic [SHIFT_WIDTH-1:0]              shift_q, shift_d;
    logic [COMPUTE_DATA_WIDTH-1:0]       out_data_q, out_data_d;
    logic [IDX_WIDTH-1:0]                out_index_q, out_index_d;
    logic                                out_valid_q, out_valid_d;
    logic                                busy_q, busy_d;
    logic                                acc_clear_q, acc_clear_d;
    logic                                done_q, done_d;
    logic                                out_last_q, out_last_d;

    logic [IDX_WIDTH-1:0]                nxt_idx;
    logic [ACCUMULATOR_DATA_WIDTH-1:0]   rq_acc;
    logic [SHIFT_WIDTH-1:0]              rq_shift;
    logic [COMPUTE_DATA_WIDTH-1:0]       rq_data;

    // One requant unit: fed from the live array on capture, from the snapshot while streaming.
    always_comb begin
        nxt_idx = (out_index_q == LAST_IDX) ? '0 : IDX_WIDTH'(out_index_q + 1'b1);
        if (state_q == IDLE) begin
            rq_acc   = accumulator[0];
            rq_shift = shift;
        end else begin
            rq_acc   = snap_q[nxt_idx];
            rq_shift = shift_q;
        end
    end

    mac_requant #(
        .ADW (ACCUMULATOR_DATA_WIDTH),
        .CDW (COMPUTE_DATA_WIDTH),
        .SW  (SHIFT_WIDTH)
    ) u_requant (
        .acc_i   (rq_acc),
        .shift_i (rq_shift),
        .data_o  (rq_data)
    );

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        shift_d     = shift_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        out_last_d  = out_last_q;
        acc_clear_d = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d      = accumulator;
                    shift_d     = shift;
                    out_data_d  = rq_data;
                    out_index_d = '0;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    acc_clear_d = 1'b1;
                    out_last_d  = (LAST_IDX == '0);
                    state_d     = STREAM;
                end
            end
            STREAM: begin
                if (out_valid_q && out_ready) begin
                    if (out_index_q == LAST_IDX) begin
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        out_index_d = nxt_idx;
                        out_data_d  = rq_data;
                        out_last_d  = (nxt_idx == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            for (int i = 0; i < ARRAY_SIZE; i++) begin
                snap_q[i] <= '0;
            end
            shift_q     <= '0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            acc_clear_q <= 1'b0;
            done_q      <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            shift_q     <= shift_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            acc_clear_q <= acc_clear_d;
            done_q      <= done_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign acc_clear = acc_clear_q;
    assign done      = done_q;
    assign out_last  = out_last_q;

endmodule

// File: doc/mac_drain.md
# mac_drain

Read-out engine for the MAC array: on command it snapshots all `ARRAY_SIZE` accumulators, pulses a clear back to the array, then streams each value out over a valid/ready port. Each value is arithmetically right-shifted with round-half-up and saturated to `COMPUTE_DATA_WIDTH`. It sits between the MAC array's `accumulator` outputs and the result buffer, so the next layer receives operands at compute precision.

## Interface
- `ARRAY_SIZE`, 2, number of accumulators (≥1)
- `COMPUTE_DATA_WIDTH`, 4, output element width, signed
- `ACCUMULATOR_DATA_WIDTH`, 16, accumulator width, signed
- `SHIFT_WIDTH`, `$clog2(ACCUMULATOR_DATA_WIDTH)`, width of requant shift
- `IDX_WIDTH`, `(ARRAY_SIZE>1) ? $clog2(ARRAY_SIZE) : 1`, element index width
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  request to drain; sampled only when idle
- `shift`  in  `SHIFT_WIDTH`  right-shift amount, captured with `start`
- `accumulator`  in  `[ACCUMULATOR_DATA_WIDTH-1:0]` x `ARRAY_SIZE`  MAC array results
- `acc_clear`  out  1  one-cycle clear pulse to the MAC array
- `busy`  out  1  high from capture until last element is accepted
- `out_valid`  out  1  `out_data` holds a valid element
- `out_ready`  in  1  downstream accepts the element
- `out_data`  out  `COMPUTE_DATA_WIDTH`  requantized element, signed
- `out_index`  out  `IDX_WIDTH`  accumulator index of `out_data`
- `out_last`  out  1  `out_data` is element `ARRAY_SIZE-1`
- `done`  out  1  one-cycle pulse after the last transfer

## Operation
- FSM states: IDLE, STREAM.
- IDLE with `start`=1 at an edge:
  - snapshot `accumulator[]` and `shift` into registers;
  - `out_data` <= requant(`accumulator[0]`), `out_index`<=0, `out_valid`<=1, `busy`<=1, `acc_clear`<=1;
  - go to STREAM.
- STREAM:
  - `acc_clear` is 0 after its first cycle.
  - On a transfer (`out_valid`&&`out_ready`) that is not the last element: `out_index`++ and `out_data` <= requant(snapshot[`out_index`+1]).
  - On the transfer of the last element: `out_valid`<=0, `busy`<=0, `done`<=1 for one cycle, go to IDLE.
- `start` during STREAM is ignored, with no queuing. `start` in the same cycle as `done` is high is accepted, because the FSM is already IDLE.
- `out_last` = `out_valid` && (`out_index`==`ARRAY_SIZE-1`). With `ARRAY_SIZE`=1 the first element is also the last.
- Requant, signed, computed at `ACCUMULATOR_DATA_WIDTH+1` bits:
  - if `shift`==0: t = a; else t = (a + (1<<(shift-1))) >>> shift;
  - saturate t to [-2^(CDW-1), 2^(CDW-1)-1].
- The snapshot decouples the stream from the array, so the array may resume accumulating after `acc_clear`.
- Reset (`rst`=0, any time including mid-stream): FSM→IDLE; `out_valid`, `busy`, `acc_clear`, `done`, `out_last` = 0; `out_data`, `out_index`, snapshot, stored shift = 0. No `done` is issued for an aborted drain.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- `start` sampled at edge N:
  - `out_valid`, `busy` and `acc_clear` are high in cycle N+1;
  - `acc_clear` is low again in cycle N+2.
- Throughput is one element per cycle with `out_ready` held high. The drain takes `ARRAY_SIZE` cycles from the first `out_valid` to the last transfer, and `done` follows in the next cycle.
- While `out_valid`=1 and `out_ready`=0, `out_data`, `out_index` and `out_last` are held stable.
- `out_valid` never drops without a transfer, except on reset.

## Structure
- Shared package `mac_pkg`: a `requant` function parameterized by widths, and the FSM state enum `drain_state_t` (IDLE, STREAM).
- One sub-module, `mac_requant`: combinational shift, round and saturate. It is instantiated once and muxes its input between `accumulator[0]` (capture) and the snapshot element.

## Test plan
All cases use `ARRAY_SIZE`=2, CDW=4, ADW=16.
- acc={5,-3}, shift=0, ready=1 → out 5 (idx0), -3 (idx1, last); `done` 1 cycle after; `acc_clear` exactly 1 cycle.
- acc={100,-100}, shift=0 → outputs 7 then -8 (saturation).
- acc={10,-10}, shift=2 → outputs 3 then -2 (round-half-up).
- Backpressure: `out_ready` low for 3 cycles at idx0 → `out_data`=5, `out_index`=0 held; then both elements delivered in order.
- `start` pulsed during STREAM with new acc={1,1} → ignored; original values streamed; a new `start` on the `done` cycle is accepted.
- `rst` low while idx1 pending → all outputs 0 next cycle, no `done`; the next `start` runs a full drain correctly.
